// File: rtl/vdf_square_sequencer.sv
// vdf_square_sequencer
// Host-side job controller for an iterative modular squarer. It accepts
// (x, T), launches the squarer, counts completed squarings, captures the
// result at T (or at abort), parks the squarer in reset and returns the
// result through a ready/valid handshake.
//
// Optional feature: define VDF_SEQ_TIMEOUT_EN to add a RUN-state watchdog
// that ends a job as if aborted after TIMEOUT cycles without a sq_valid.
// All outputs come straight from flops; nothing is combinational from inputs.

module vdf_square_sequencer #(
    parameter int MOD_LEN = 1024,
    parameter int CNT_W   = 64,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    // host job request
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [MOD_LEN-1:0] load_value,
    input  logic [CNT_W-1:0]   load_iters,
    input  logic               abort,
    // host result
    output logic               res_valid,
    input  logic               res_ready,
    output logic [MOD_LEN-1:0] res_value,
    output logic [CNT_W-1:0]   res_iters,
    output logic               res_error,
    // squarer core
    output logic               sq_reset,
    output logic               sq_start,
    output logic [MOD_LEN-1:0] sq_in,
    input  logic [MOD_LEN-1:0] sq_out,
    input  logic               sq_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_PARK,
        S_DONE
    } state_t;

    // LAUNCH and PARK both last two cycles; r_phase selects the cycle.
    state_t             r_state;
    state_t             w_state_next;
    logic               r_phase;
    logic               w_phase_next;

    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   w_target_next;
    logic [CNT_W-1:0]   w_count_inc;

    logic [MOD_LEN-1:0] r_sq_in;
    logic [MOD_LEN-1:0] w_sq_in_next;
    logic [MOD_LEN-1:0] r_res_value;
    logic [MOD_LEN-1:0] w_res_value_next;
    logic [CNT_W-1:0]   r_res_iters;
    logic [CNT_W-1:0]   w_res_iters_next;
    logic               r_res_error;
    logic               w_res_error_next;

    logic               r_load_ready;
    logic               r_res_valid;
    logic               r_sq_reset;
    logic               r_sq_start;

    logic               w_final;
    logic               w_timeout;

    assign w_count_inc = r_count + CNT_W'(1);
    // The squaring that brings count up to target completes the job; it wins
    // over a simultaneous abort or watchdog expiry.
    assign w_final     = sq_valid && (w_count_inc == r_target);

`ifdef VDF_SEQ_TIMEOUT_EN
    localparam int            WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_wdog;

    // Watchdog: idle RUN cycles since sq_start or the last sq_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog <= '0;
        end else if (r_state != S_RUN || sq_valid) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + WD_W'(1);
        end
    end

    // Expires on the TIMEOUT-th consecutive RUN cycle without a squaring.
    assign w_timeout = (r_state == S_RUN) && !sq_valid && (r_wdog == WD_LAST);
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT > 0);
    assign w_timeout            = 1'b0;
`endif

    // Next-state, datapath and result-capture decisions.
    always_comb begin
        w_state_next     = r_state;
        w_phase_next     = r_phase;
        w_count_next     = r_count;
        w_target_next    = r_target;
        w_sq_in_next     = r_sq_in;
        w_res_value_next = r_res_value;
        w_res_iters_next = r_res_iters;
        w_res_error_next = r_res_error;

        case (r_state)
            S_IDLE: begin
                if (load_valid) begin
                    w_sq_in_next  = load_value;
                    w_target_next = load_iters;
                    w_count_next  = '0;
                    w_phase_next  = 1'b0;
                    if (load_iters != '0) begin
                        w_state_next = S_LAUNCH;
                    end else begin
                        // x^(2^0) = x: answer directly, squarer stays parked.
                        w_res_value_next = load_value;
                        w_res_iters_next = '0;
                        w_res_error_next = 1'b0;
                        w_state_next     = S_DONE;
                    end
                end
            end

            S_LAUNCH: begin
                if (abort) begin
                    w_res_value_next = sq_out;
                    w_res_iters_next = r_count;
                    w_res_error_next = 1'b1;
                    w_phase_next     = 1'b0;
                    w_state_next     = S_PARK;
                end else if (!r_phase) begin
                    w_phase_next = 1'b1;
                end else begin
                    w_phase_next = 1'b0;
                    w_state_next = S_RUN;
                end
            end

            S_RUN: begin
                if (w_final) begin
                    w_count_next     = r_target;
                    w_res_value_next = sq_out;
                    w_res_iters_next = r_target;
                    w_res_error_next = 1'b0;
                    w_phase_next     = 1'b0;
                    w_state_next     = S_PARK;
                end else begin
                    if (sq_valid) begin
                        w_count_next = w_count_inc;
                    end
                    if (abort || w_timeout) begin
                        // A squaring landing in the abort cycle still counts.
                        w_res_value_next = sq_out;
                        w_res_iters_next = sq_valid ? w_count_inc : r_count;
                        w_res_error_next = 1'b1;
                        w_phase_next     = 1'b0;
                        w_state_next     = S_PARK;
                    end
                end
            end

            S_PARK: begin
                if (!r_phase) begin
                    w_phase_next = 1'b1;
                end else begin
                    w_phase_next = 1'b0;
                    w_state_next = S_DONE;
                end
            end

            S_DONE: begin
                if (r_res_valid && res_ready) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_phase_next = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs (decoded from next state).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_phase      <= 1'b0;
            r_count      <= '0;
            r_target     <= '0;
            r_sq_in      <= '0;
            r_res_value  <= '0;
            r_res_iters  <= '0;
            r_res_error  <= 1'b0;
            r_load_ready <= 1'b1;
            r_res_valid  <= 1'b0;
            r_sq_reset   <= 1'b1;
            r_sq_start   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_phase      <= w_phase_next;
            r_count      <= w_count_next;
            r_target     <= w_target_next;
            r_sq_in      <= w_sq_in_next;
            r_res_value  <= w_res_value_next;
            r_res_iters  <= w_res_iters_next;
            r_res_error  <= w_res_error_next;
            r_load_ready <= (w_state_next == S_IDLE);
            r_res_valid  <= (w_state_next == S_DONE);
            r_sq_reset   <= (w_state_next == S_IDLE) || (w_state_next == S_PARK) ||
                            (w_state_next == S_DONE);
            r_sq_start   <= (w_state_next == S_LAUNCH) && w_phase_next;
        end
    end

    assign load_ready = r_load_ready;
    assign res_valid  = r_res_valid;
    assign res_value  = r_res_value;
    assign res_iters  = r_res_iters;
    assign res_error  = r_res_error;
    assign sq_reset   = r_sq_reset;
    assign sq_start   = r_sq_start;
    assign sq_in      = r_sq_in;

endmodule

// File: tb/tb_vdf_square_sequencer.sv
// Directed testbench for vdf_square_sequencer with a behavioural squarer
// model that pulses sq_valid every PERIOD cycles after sq_start.
// Watchdog scenario runs when VDF_SEQ_TIMEOUT_EN is defined (TIMEOUT=64).

module tb_vdf_square_sequencer;

    localparam int MOD_LEN = 1024;
    localparam int CNT_W   = 64;
    localparam int TIMEOUT = 64;
    localparam int PERIOD  = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               load_valid;
    logic               load_ready;
    logic [MOD_LEN-1:0] load_value;
    logic [CNT_W-1:0]   load_iters;
    logic               abort;
    logic               res_valid;
    logic               res_ready;
    logic [MOD_LEN-1:0] res_value;
    logic [CNT_W-1:0]   res_iters;
    logic               res_error;
    logic               sq_reset;
    logic               sq_start;
    logic [MOD_LEN-1:0] sq_in;
    logic [MOD_LEN-1:0] sq_out;
    logic               sq_valid;

    vdf_square_sequencer #(
        .MOD_LEN(MOD_LEN),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_value(load_value),
        .load_iters(load_iters),
        .abort     (abort),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_value (res_value),
        .res_iters (res_iters),
        .res_error (res_error),
        .sq_reset  (sq_reset),
        .sq_start  (sq_start),
        .sq_in     (sq_in),
        .sq_out    (sq_out),
        .sq_valid  (sq_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // squarer model state
    int                 m_k      = 0;
    int                 m_starts = 0;
    int                 m_gap    = 0;
    logic               m_active = 1'b0;
    logic               m_stall  = 1'b0;
    logic [MOD_LEN-1:0] m_start_in = '0;

    logic [MOD_LEN-1:0] x1;
    logic [MOD_LEN-1:0] x2;

    // Known output for the k-th squaring of a job.
    function automatic logic [MOD_LEN-1:0] sq_val(input int k);
        logic [63:0] w;
        w = 64'hC0DE_0000_0000_0000 | 64'(k);
        return {16{w}};
    endfunction

    task automatic check(input string tag, input logic [MOD_LEN-1:0] got,
                         input logic [MOD_LEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got(lo128)=%h exp(lo128)=%h", tag, got[127:0], exp[127:0]);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_job(input logic [MOD_LEN-1:0] x, input logic [CNT_W-1:0] t);
        check("load_ready_pre", MOD_LEN'(load_ready), MOD_LEN'(1));
        load_valid = 1'b1;
        load_value = x;
        load_iters = t;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic wait_valid_k(input string tag, input int k);
        bit found;
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            if (sq_valid && m_k == k) begin
                found = 1;
                break;
            end
            tick();
        end
        check(tag, MOD_LEN'(found), MOD_LEN'(1));
    endtask

    task automatic wait_res(input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            if (res_valid) begin
                found = 1;
                break;
            end
            tick();
        end
        check(tag, MOD_LEN'(found), MOD_LEN'(1));
    endtask

    task automatic handshake(input string tag);
        $display("job %s: iters=%0d error=%0d value(lo64)=%h", tag, res_iters, res_error,
                 res_value[63:0]);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_hs_valid"}, MOD_LEN'(res_valid), MOD_LEN'(0));
        check({tag, "_hs_ready"}, MOD_LEN'(load_ready), MOD_LEN'(1));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_load_ready"}, MOD_LEN'(load_ready), MOD_LEN'(1));
        check({tag, "_sq_reset"},   MOD_LEN'(sq_reset),   MOD_LEN'(1));
        check({tag, "_sq_start"},   MOD_LEN'(sq_start),   MOD_LEN'(0));
        check({tag, "_res_valid"},  MOD_LEN'(res_valid),  MOD_LEN'(0));
        check({tag, "_res_error"},  MOD_LEN'(res_error),  MOD_LEN'(0));
        check({tag, "_res_value"},  res_value,            '0);
        check({tag, "_res_iters"},  MOD_LEN'(res_iters),  '0);
        check({tag, "_sq_in"},      sq_in,                '0);
    endtask

    // Behavioural squarer: drives sq_valid/sq_out on the falling edge.
    initial begin
        sq_valid = 1'b0;
        sq_out   = '0;
        forever begin
            @(negedge clk);
            sq_valid = 1'b0;
            if (sq_reset) begin
                m_active = 1'b0;
                m_gap    = 0;
            end else if (sq_start) begin
                m_active   = 1'b1;
                m_k        = 0;
                m_gap      = 0;
                m_starts++;
                m_start_in = sq_in;
            end else if (m_active && !m_stall) begin
                m_gap++;
                if (m_gap == PERIOD) begin
                    m_gap    = 0;
                    m_k++;
                    sq_valid = 1'b1;
                    sq_out   = sq_val(m_k);
                end
            end
        end
    end

    // Hard stop in case the sequence itself wedges.
    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        int starts0;
        int cyc;
        x1 = {16{64'h1234_5678_9abc_def0}};
        x2 = {16{64'h0f1e_2d3c_4b5a_6978}};

        reset      = 1'b1;
        load_valid = 1'b0;
        load_value = '0;
        load_iters = '0;
        abort      = 1'b0;
        res_ready  = 1'b0;
        tick();
        tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();

        // Basic job, T=5
        starts0 = m_starts;
        load_job(x1, 64'd5);
        check("t5_start_c1", MOD_LEN'(sq_start), MOD_LEN'(0));
        check("t5_sqrst_c1", MOD_LEN'(sq_reset), MOD_LEN'(0));
        tick();
        check("t5_start_c2", MOD_LEN'(sq_start), MOD_LEN'(1));
        check("t5_sq_in",    sq_in,              x1);
        tick();
        check("t5_start_c3", MOD_LEN'(sq_start), MOD_LEN'(0));
        wait_valid_k("t5_wait5", 5);
        tick();
        check("t5_rv_p1", MOD_LEN'(res_valid), MOD_LEN'(0));
        tick();
        check("t5_rv_p2", MOD_LEN'(res_valid), MOD_LEN'(0));
        tick();
        check("t5_rv_p3",   MOD_LEN'(res_valid), MOD_LEN'(1));
        check("t5_value",   res_value,           sq_val(5));
        check("t5_iters",   MOD_LEN'(res_iters), MOD_LEN'(5));
        check("t5_error",   MOD_LEN'(res_error), MOD_LEN'(0));
        check("t5_nstarts", MOD_LEN'(m_starts - starts0), MOD_LEN'(1));
        check("t5_model_in", m_start_in,         x1);
        handshake("t5");

        // T=0: answered directly, squarer untouched
        starts0 = m_starts;
        load_job(x2, 64'd0);
        check("t0_rv",     MOD_LEN'(res_valid), MOD_LEN'(1));
        check("t0_value",  res_value,           x2);
        check("t0_iters",  MOD_LEN'(res_iters), MOD_LEN'(0));
        check("t0_error",  MOD_LEN'(res_error), MOD_LEN'(0));
        check("t0_sqrst",  MOD_LEN'(sq_reset),  MOD_LEN'(1));
        check("t0_start",  MOD_LEN'(sq_start),  MOD_LEN'(0));
        tick();
        check("t0_sqrst2", MOD_LEN'(sq_reset),  MOD_LEN'(1));
        check("t0_nstarts", MOD_LEN'(m_starts - starts0), MOD_LEN'(0));
        handshake("t0");

        // Abort after the 37th squaring of T=100
        load_job(x1, 64'd100);
        wait_valid_k("ab_wait37", 37);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_sqrst", MOD_LEN'(sq_reset),  MOD_LEN'(1));
        check("ab_iters", MOD_LEN'(res_iters), MOD_LEN'(37));
        check("ab_error", MOD_LEN'(res_error), MOD_LEN'(1));
        check("ab_value", res_value,           sq_val(37));
        wait_res("ab_wait_res");
        check("ab_error_done", MOD_LEN'(res_error), MOD_LEN'(1));
        handshake("abort");

        // Abort coinciding with the final squaring: completion wins
        load_job(x2, 64'd3);
        wait_valid_k("sim_wait3", 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("sim_sqrst", MOD_LEN'(sq_reset),  MOD_LEN'(1));
        check("sim_error", MOD_LEN'(res_error), MOD_LEN'(0));
        check("sim_iters", MOD_LEN'(res_iters), MOD_LEN'(3));
        check("sim_value", res_value,           sq_val(3));
        wait_res("sim_wait_res");
        handshake("simul");

        // Backpressure with a pending second load
        load_job(x1, 64'd2);
        wait_res("bp_wait_res");
        load_valid = 1'b1;
        load_value = x2;
        load_iters = 64'd0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_load_ready", MOD_LEN'(load_ready), MOD_LEN'(0));
            check("bp_res_valid",  MOD_LEN'(res_valid),  MOD_LEN'(1));
            check("bp_value",      res_value,            sq_val(2));
            check("bp_iters",      MOD_LEN'(res_iters),  MOD_LEN'(2));
        end
        $display("job bp1: iters=%0d error=%0d value(lo64)=%h", res_iters, res_error,
                 res_value[63:0]);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_hs_ready", MOD_LEN'(load_ready), MOD_LEN'(1));
        check("bp_hs_valid", MOD_LEN'(res_valid),  MOD_LEN'(0));
        tick();
        load_valid = 1'b0;
        check("bp_j2_rv",    MOD_LEN'(res_valid),  MOD_LEN'(1));
        check("bp_j2_value", res_value,            x2);
        check("bp_j2_ready", MOD_LEN'(load_ready), MOD_LEN'(0));
        handshake("bp2");

        // Reset while RUN
        load_job(x1, 64'd50);
        wait_valid_k("rr_wait4", 4);
        check("rr_running", MOD_LEN'(sq_reset), MOD_LEN'(0));
        reset = 1'b1;
        #1;
        check_reset_values("rr");
        tick();
        reset = 1'b0;
        tick();
        check("rr_after_ready", MOD_LEN'(load_ready), MOD_LEN'(1));

        // Stalled squarer
        m_stall = 1'b1;
        load_job(x2, 64'd4);
        tick();
        check("st_start", MOD_LEN'(sq_start), MOD_LEN'(1));
`ifdef VDF_SEQ_TIMEOUT_EN
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (res_valid) begin
                cyc = i;
                break;
            end
        end
        check("wd_latency", MOD_LEN'(cyc),       MOD_LEN'(TIMEOUT + 3));
        check("wd_error",   MOD_LEN'(res_error), MOD_LEN'(1));
        check("wd_iters",   MOD_LEN'(res_iters), MOD_LEN'(0));
        handshake("watchdog");
`else
        cyc = 0;
        repeat (100) begin
            tick();
            if (res_valid) cyc++;
        end
        check("st_no_result", MOD_LEN'(cyc),      MOD_LEN'(0));
        check("st_running",   MOD_LEN'(sq_reset), MOD_LEN'(0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("st_ab_sqrst", MOD_LEN'(sq_reset),  MOD_LEN'(1));
        check("st_ab_error", MOD_LEN'(res_error), MOD_LEN'(1));
        check("st_ab_iters", MOD_LEN'(res_iters), MOD_LEN'(0));
        wait_res("st_wait_res");
        handshake("stall");
`endif
        m_stall = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
